// File: rtl/mcu_rd_ctrl.sv
// Readback address generator: programmable base/length, ring wrap at DEPTH, channel index.
// Optional MCU_RD_ERR_EN adds rd_err/err_cnt reporting of stray read strobes.
module mcu_rd_ctrl #(
  parameter int unsigned     ADDR_W = 20,
  parameter longint unsigned DEPTH  = 64'h80000,
  parameter int unsigned     NUM_CH = 1,
  parameter int unsigned     CH_W   = 1
) (
  input  logic              mcu_rd_clk,
  input  logic              rst,
  input  logic              sample_end,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] rd_len,
  input  logic              wrap_mode,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [CH_W-1:0]   ch_idx,
  output logic              rd_ack,
  output logic              rd_busy,
  output logic              rd_done
`ifdef MCU_RD_ERR_EN
  ,
  output logic              rd_err,
  output logic [7:0]        err_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DONE
  } state_t;

  localparam logic [ADDR_W:0] LP_DEPTH   = (ADDR_W+1)'(DEPTH);
  localparam logic [CH_W-1:0] LP_CH_LAST = CH_W'(NUM_CH - 1);

  state_t            r_state;
  logic              r_se_d;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_len;
  logic              r_wrap;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [CH_W-1:0]   r_ch;
  logic              r_ack;
  logic              r_busy;
  logic              r_done;

  logic              w_rise;
  logic [ADDR_W:0]   w_addr_sum;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [ADDR_W:0]   w_cnt_sum;
  logic              w_last;
  logic [CH_W-1:0]   w_ch_nxt;

  // Sums are one bit wider so DEPTH = 2^ADDR_W compares without overflow
  always_comb begin
    w_rise     = sample_end & ~r_se_d;
    w_addr_sum = {1'b0, r_addr} + (ADDR_W+1)'(1);
    w_addr_nxt = (w_addr_sum == LP_DEPTH) ? '0 : w_addr_sum[ADDR_W-1:0];
    w_cnt_sum  = {1'b0, r_cnt} + (ADDR_W+1)'(1);
    w_last     = (w_cnt_sum == {1'b0, r_len});
    w_ch_nxt   = (r_ch == LP_CH_LAST) ? '0 : r_ch + CH_W'(1);
  end

  always_ff @(posedge mcu_rd_clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_se_d  <= 1'b0;
      r_base  <= '0;
      r_len   <= '0;
      r_wrap  <= 1'b0;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_ch    <= '0;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_se_d <= sample_end;
      r_ack  <= 1'b0;
      // A low sample_end aborts from any state and drops any concurrent rd_req
      if (!sample_end) begin
        r_state <= ST_IDLE;
        r_addr  <= '0;
        r_ch    <= '0;
        r_cnt   <= '0;
        r_busy  <= 1'b0;
        r_done  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_rise) begin
              r_base <= base_addr;
              r_len  <= rd_len;
              r_wrap <= wrap_mode;
              r_addr <= base_addr;
              r_cnt  <= '0;
              r_ch   <= '0;
              if (rd_len == '0) begin
                r_state <= ST_DONE;
                r_done  <= 1'b1;
              end else begin
                r_state <= ST_READ;
                r_busy  <= 1'b1;
              end
            end
          end
          ST_READ: begin
            if (rd_req) begin
              r_ack <= 1'b1;
              if (w_last && r_wrap) begin
                r_addr <= r_base;
                r_cnt  <= '0;
                r_ch   <= '0;
              end else begin
                r_addr <= w_addr_nxt;
                r_cnt  <= w_cnt_sum[ADDR_W-1:0];
                r_ch   <= w_ch_nxt;
                if (w_last) begin
                  r_state <= ST_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                end
              end
            end
          end
          ST_DONE: begin
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign mem_addr = r_addr;
  assign ch_idx   = r_ch;
  assign rd_ack   = r_ack;
  assign rd_busy  = r_busy;
  assign rd_done  = r_done;

`ifdef MCU_RD_ERR_EN
  logic       r_err;
  logic [7:0] r_err_cnt;
  logic       w_stray;
  logic       w_arm;

  always_comb begin
    w_stray = rd_req && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    w_arm   = w_rise && (r_state == ST_IDLE);
  end

  always_ff @(posedge mcu_rd_clk) begin
    if (rst) begin
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_err <= w_stray;
      if (w_arm)
        r_err_cnt <= '0;
      else if (w_stray && (r_err_cnt != 8'hFF))
        r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign rd_err  = r_err;
  assign err_cnt = r_err_cnt;
`endif

endmodule
